// File: rtl/mul32_pkg.sv
// Shared constants and FSM state encoding for the shift-and-add multiplier.
package mul32_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/fulladder32.sv
// 32-bit ripple-carry adder, purely combinational: S = A + B + Pin, Pout = carry out.
module fulladder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Pin,
    output logic [31:0] S,
    output logic        Pout
);
    logic [32:0] carry;

    assign carry[0] = Pin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign S[i]       = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign Pout = carry[32];
endmodule

// File: rtl/mul32_shift_add.sv
// Sequential unsigned 32x32->64 multiplier, one add-and-shift per clock; done 32 clocks after an accepted start.
// start is ignored while busy; build option MUL32_ZERO_BYPASS_EN finishes zero-operand jobs in one clock.
module mul32_shift_add #(
    parameter int WIDTH = mul32_pkg::WIDTH,
    parameter int CNT_W = mul32_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    import mul32_pkg::*;

    if (WIDTH != 32) begin : g_bad_width
        $error("mul32_shift_add: WIDTH must equal the adder width (32)");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
        $error("mul32_shift_add: CNT_W too narrow to count WIDTH iterations");
    end

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               zero_op;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_s;
    logic               add_c;

    // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
    assign add_a = p[2*WIDTH-1:WIDTH];
    assign add_b = p[0] ? mcand : '0;

    fulladder32 u_add (
        .A    (add_a),
        .B    (add_b),
        .Pin  (1'b0),
        .S    (add_s),
        .Pout (add_c)
    );

`ifdef MUL32_ZERO_BYPASS_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: accept = start;
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                accept    = start;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            state_nxt = zero_op ? DONE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            p     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand <= a;
                p     <= zero_op ? '0 : {{WIDTH{1'b0}}, b};
                cnt   <= '0;
            end else if (state == RUN) begin
                // 65-bit {carry, sum, low bits} shifted right by one.
                p   <= {add_c, add_s, p[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign product = p;
endmodule
